// File: rtl/fp_op_scheduler_if.sv
// Handshake and datapath bundle between two requesters, the op scheduler,
// the shared Sumador datapath and the response consumer.
`timescale 1ns/1ps
interface fp_op_scheduler_if #(parameter int W = 32);
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [W-1:0] dp_a;
  logic [W-1:0] dp_b;
  logic [3:0]   dp_en;
  logic         dp_cmp;
  logic [W-1:0] dp_numr;
  logic [W-1:0] dp_nums;
  logic [W-1:0] dp_num;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [1:0]   rsp_op;
  logic [W-1:0] rsp_data;
  logic         busy;

  // Environment side: requesters, datapath and response consumer.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  dp_a, dp_b, dp_en,
    output dp_cmp, dp_numr, dp_nums, dp_num,
    input  rsp_valid, rsp_id, rsp_op, rsp_data, busy,
    output rsp_ready
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output dp_a, dp_b, dp_en,
    input  dp_cmp, dp_numr, dp_nums, dp_num,
    output rsp_valid, rsp_id, rsp_op, rsp_data, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/fp_op_scheduler.sv
// Round-robin sequencer for the shared FP compare/add/subtract datapath:
// accept a request, hold the enable for LAT cycles, capture, respond.
`timescale 1ns/1ps
module fp_op_scheduler #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input logic              clk,
  input logic              rst,
  fp_op_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t       state;
  logic         last_grant;
  logic [3:0]   cnt;
  logic         grant;
  logic         accept;
  logic [1:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [W-1:0] result;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  // Ready is gated by rst so it reads 0 while reset is held.
  assign bus.req0_ready = (state == IDLE) && !rst && bus.req0_valid && !grant;
  assign bus.req1_ready = (state == IDLE) && !rst && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign sel_op = grant ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

  always_comb begin
    result = '0;
    case (bus.rsp_op)
      2'd0:    result = {{(W-1){1'b0}}, bus.dp_cmp};
      2'd1:    result = bus.dp_numr;
      2'd2:    result = bus.dp_nums;
      default: result = bus.dp_num;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cnt           <= '0;
      bus.dp_a      <= '0;
      bus.dp_b      <= '0;
      bus.dp_en     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_op    <= '0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.dp_a   <= sel_a;
            bus.dp_b   <= sel_b;
            bus.dp_en  <= 4'b0001 << sel_op;
            bus.rsp_op <= sel_op;
            bus.rsp_id <= grant;
            last_grant <= grant;
            cnt        <= LAT_CNT;
            bus.busy   <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The enable is still asserted on this edge, so the datapath output is settled.
          if (cnt == 4'd1) begin
            bus.rsp_data  <= result;
            bus.rsp_valid <= 1'b1;
            bus.dp_en     <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_op_scheduler.md
# fp_op_scheduler

Arbitrating sequencer for the shared floating-point compare/add/subtract datapath (`Sumador`). It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It drives the datapath operands and the one-hot enable for a fixed settling window, then captures the selected result. It returns the result with the requester ID over a response handshake, and replaces button-stepped result cycling with a deterministic issue/capture sequence.

## Interface
Parameters:
- `W`, 32: operand/result width.
- `LAT`, 2: datapath settling cycles between issue and capture; legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  scheduler accepts requester 0 this cycle.
- `req0_op`  in  2  opcode: 00 compare, 01 subtract (`numr`), 10 sum (`nums`), 11 raw/normalized (`num`).
- `req0_a`, `req0_b`  in  W  operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same meaning, requester 1.
- `dp_a`, `dp_b`  out  W  operands to datapath.
- `dp_en`  out  4  one-hot datapath enable: bit k set for opcode k.
- `dp_cmp`  in  1  datapath compare result.
- `dp_numr`, `dp_nums`, `dp_num`  in  W  datapath results.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_id`  out  1  requester that issued the operation.
- `rsp_op`  out  2  opcode of the operation.
- `rsp_data`  out  W  result.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- FSM states:
  - IDLE → EXEC on an accept handshake.
  - EXEC → RESP when `cnt==1`.
  - RESP → IDLE on `rsp_valid & rsp_ready`.
- IDLE:
  - `reqN_ready` is high combinationally only for the granted requester.
  - An accept is `reqN_valid & reqN_ready`.
- Arbitration:
  - A single valid requester is granted.
  - If both are valid, the requester other than `last_grant` is granted.
  - `last_grant` updates on accept and resets to 1, so requester 0 wins the first tie.
- Accept edge:
  - Latch `reqN_a/b` into `dp_a/dp_b`.
  - Latch the opcode and ID.
  - Load `cnt = LAT`.
- EXEC:
  - `dp_en = 1 << op`.
  - `cnt` decrements each cycle.
  - On the edge where `cnt==1`, capture `rsp_data` and enter RESP:
    - op 00: `{W-1 zeros, dp_cmp}`
    - op 01: `dp_numr`
    - op 10: `dp_nums`
    - op 11: `dp_num`
- `dp_en` is 0 in IDLE and RESP.
- `dp_a`/`dp_b` hold their last accepted values until the next accept; they are never glitched back to 0 between operations.
- RESP:
  - `rsp_valid=1`; `rsp_id`, `rsp_op` and `rsp_data` are stable until the handshake.
  - Both `reqN_ready` are 0.
- Valid dropped without a handshake: legal, nothing latched.
- `reqN_op`/operands are ignored except on the accept edge.

## Timing
- Reset value of every output is 0: `dp_a`, `dp_b`, `dp_en`, `rsp_*`, `busy`, `reqN_ready`. State is IDLE and `last_grant=1`.
- Reset asserted mid-EXEC or mid-RESP aborts the operation: no response is produced, and `dp_en` drops to 0 immediately (asynchronously).
- Accept at edge t0:
  - `dp_en` is non-zero for cycles t0+1..t0+LAT (LAT cycles).
  - `rsp_valid` rises after edge t0+LAT.
- Response handshake at edge t1:
  - IDLE from t1.
  - Earliest next accept is at edge t1+1 (`reqN_ready` is seen after t1).
  - Minimum issue interval is LAT+2 cycles.
- `rsp_ready` held high while RESP is entered: the handshake completes on the first RESP cycle.
- `reqN_valid` rising during EXEC/RESP waits; it is arbitrated on return to IDLE.

## Test plan
- Reset, then `req0` op 10, A=0x3F800000 (1.0), B=0x40000000 (2.0), LAT=2 → `dp_en=0100` for 2 cycles; `rsp_valid` 2 cycles after accept with `rsp_data=0x40400000`, `rsp_id=0`, `rsp_op=10`.
- Both requesters valid continuously from reset, with `rsp_ready=1` → grants alternate 0,1,0,1; accepts spaced exactly LAT+2 cycles; `req1` data returned with `rsp_id=1`.
- Op 00 with A=0x40000000, B=0x3F800000, model `dp_cmp=1` → `rsp_data=0x00000001`; with `dp_cmp=0` → `0x00000000`.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_valid` and `rsp_data` are held stable, both ready are 0, and `dp_en=0` throughout; the handshake returns the FSM to IDLE.
- Assert `rst` for 1 cycle during EXEC (cnt=1 remaining) → all outputs 0 immediately, no `rsp_valid` ever; next tie is granted to requester 0.
- LAT=1 build, op 11 → `dp_en=1000` for one cycle; `rsp_data=dp_num` sampled on that cycle; `busy` is high for exactly 2 cycles with `rsp_ready=1`.
